// File: rtl/ram_arbiter.sv
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-master arbiter/sequencer for the shared byte-write data RAM,
//            with lock-based ownership. Optional macro: ARB_ROUND_ROBIN_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef WIDTH
`define WIDTH 32
`endif

module ram_arbiter #(
   parameter int unsigned SIZE = 32'd12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_m0_req,
   input  logic [3:0]          i_m0_we,
   input  logic [SIZE-3:0]     i_m0_addr,
   input  logic [`WIDTH-1:0]   i_m0_wdata,
   input  logic                i_m0_lock,
   input  logic                i_m1_req,
   input  logic [3:0]          i_m1_we,
   input  logic [SIZE-3:0]     i_m1_addr,
   input  logic [`WIDTH-1:0]   i_m1_wdata,
   input  logic                i_m1_lock,
   output logic                o_m0_gnt,
   output logic                o_m1_gnt,
   output logic                o_m0_ack,
   output logic                o_m1_ack,
   output logic [`WIDTH-1:0]   o_m0_rdata,
   output logic [`WIDTH-1:0]   o_m1_rdata,
   output logic                o_ram_ren,
   output logic [3:0]          o_ram_we,
   output logic [SIZE-3:0]     o_ram_addr,
   output logic [`WIDTH-1:0]   o_ram_din,
   input  logic [`WIDTH-1:0]   i_ram_dout
);

   localparam int unsigned c_AW = SIZE - 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } owner_st_t;

   owner_st_t           r_owner_st;
   logic                r_s1_valid;
   logic                r_s1_owner;
   logic                r_ram_ren;
   logic [3:0]          r_ram_we;
   logic [c_AW-1:0]     r_ram_addr;
   logic [`WIDTH-1:0]   r_ram_din;
   logic [1:0]          r_ack;
   logic                r_was_read;
`ifdef ARB_ROUND_ROBIN_EN
   logic                r_last;
`endif

   logic                w_gnt0;
   logic                w_gnt1;
   logic                w_xfer;
   logic [3:0]          w_we;
   logic [c_AW-1:0]     w_addr;
   logic [`WIDTH-1:0]   w_wdata;

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (rst_n) begin
         case (r_owner_st)
            ST_LOCK0: w_gnt0 = i_m0_req;
            ST_LOCK1: w_gnt1 = i_m1_req;
            default: begin
`ifdef ARB_ROUND_ROBIN_EN
               // r_last == 1 means m1 moved last, so m0 wins a tie
               if (i_m0_req && i_m1_req) begin
                  w_gnt0 = r_last;
                  w_gnt1 = ~r_last;
               end else begin
                  w_gnt0 = i_m0_req;
                  w_gnt1 = i_m1_req;
               end
`else
               w_gnt0 = i_m0_req;
               w_gnt1 = i_m1_req && !i_m0_req;
`endif
            end
         endcase
      end
   end

   assign w_xfer  = w_gnt0 | w_gnt1;
   assign w_we    = w_gnt1 ? i_m1_we    : i_m0_we;
   assign w_addr  = w_gnt1 ? i_m1_addr  : i_m0_addr;
   assign w_wdata = w_gnt1 ? i_m1_wdata : i_m0_wdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_owner_st <= ST_IDLE;
         r_s1_valid <= 1'b0;
         r_s1_owner <= 1'b0;
         r_ram_ren  <= 1'b0;
         r_ram_we   <= 4'd0;
         r_ram_addr <= '0;
         r_ram_din  <= '0;
         r_ack      <= 2'b00;
         r_was_read <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         r_last     <= 1'b1;
`endif
      end else begin
         r_s1_valid <= w_xfer;
         r_s1_owner <= w_gnt1;
         r_ram_ren  <= w_xfer && (w_we == 4'd0);
         r_ram_we   <= w_xfer ? w_we : 4'd0;
         if (w_xfer) begin
            r_ram_addr <= w_addr;
            r_ram_din  <= w_wdata;
         end
         r_ack      <= {r_s1_valid && r_s1_owner, r_s1_valid && !r_s1_owner};
         r_was_read <= r_ram_ren;
`ifdef ARB_ROUND_ROBIN_EN
         if (w_xfer) r_last <= w_gnt1;
`endif
         // A lock ends whenever the owner drops lock, whether or not it transfers
         case (r_owner_st)
            ST_IDLE: begin
               if (w_gnt0 && i_m0_lock)      r_owner_st <= ST_LOCK0;
               else if (w_gnt1 && i_m1_lock) r_owner_st <= ST_LOCK1;
            end
            ST_LOCK0: if (!i_m0_lock) r_owner_st <= ST_IDLE;
            ST_LOCK1: if (!i_m1_lock) r_owner_st <= ST_IDLE;
            default:  r_owner_st <= ST_IDLE;
         endcase
      end
   end

   assign o_m0_gnt   = w_gnt0;
   assign o_m1_gnt   = w_gnt1;
   assign o_m0_ack   = r_ack[0];
   assign o_m1_ack   = r_ack[1];
   assign o_m0_rdata = (r_ack[0] && r_was_read) ? i_ram_dout : '0;
   assign o_m1_rdata = (r_ack[1] && r_was_read) ? i_ram_dout : '0;
   assign o_ram_ren  = r_ram_ren;
   assign o_ram_we   = r_ram_we;
   assign o_ram_addr = r_ram_addr;
   assign o_ram_din  = r_ram_din;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter with a behavioural RAM and a
//            transaction-level reference model. Honours ARB_ROUND_ROBIN_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    localparam int unsigned c_SIZE = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req;
    logic [1:0]   lock;
    logic [3:0]   we    [2];
    logic [9:0]   addr  [2];
    logic [31:0]  wdata [2];
    logic         gnt0, gnt1, ack0, ack1;
    logic [31:0]  rdata0, rdata1;
    logic         ram_ren;
    logic [3:0]   ram_we;
    logic [9:0]   ram_addr;
    logic [31:0]  ram_din;
    logic [31:0]  ram_dout;
    logic         ram_clear;

    logic [31:0]  ram_arr [0:1023];
    logic [31:0]  ref_mem [0:1023];

    int n_cmp = 0;
    int n_err = 0;
    bit rr_mode;

    typedef struct {
        bit          v;
        bit          m;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    always #5 clk = ~clk;

    ram_arbiter #(.SIZE(c_SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_m0_req   (req[0]),
        .i_m0_we    (we[0]),
        .i_m0_addr  (addr[0]),
        .i_m0_wdata (wdata[0]),
        .i_m0_lock  (lock[0]),
        .i_m1_req   (req[1]),
        .i_m1_we    (we[1]),
        .i_m1_addr  (addr[1]),
        .i_m1_wdata (wdata[1]),
        .i_m1_lock  (lock[1]),
        .o_m0_gnt   (gnt0),
        .o_m1_gnt   (gnt1),
        .o_m0_ack   (ack0),
        .o_m1_ack   (ack1),
        .o_m0_rdata (rdata0),
        .o_m1_rdata (rdata1),
        .o_ram_ren  (ram_ren),
        .o_ram_we   (ram_we),
        .o_ram_addr (ram_addr),
        .o_ram_din  (ram_din),
        .i_ram_dout (ram_dout)
    );

    // Single-port RAM with byte enables and a registered read port
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 1024; i++) ram_arr[i] <= 32'd0;
            ram_dout <= 32'd0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_arr[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            if (ram_ren) ram_dout <= ram_arr[ram_addr];
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req  = 2'b00;
        lock = 2'b00;
        repeat (n) next();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 2'b11; lock = 2'b00;
        we[0] = 4'hF; we[1] = 4'hF;
        addr[0] = 10'd1; addr[1] = 10'd2;
        wdata[0] = 32'h1234_5678; wdata[1] = 32'h8765_4321;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt1, gnt0} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_gnt: got %b, expected 00", {gnt1, gnt0});
            end
            n_cmp++;
            if (ram_we !== 4'd0 || ram_ren !== 1'b0) begin
                n_err++;
                $display("FAIL reset_ram_cmd: got we=%h ren=%b, expected we=0 ren=0", ram_we, ram_ren);
            end
            n_cmp++;
            if ({ack1, ack0} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_ack: got %b, expected 00", {ack1, ack0});
            end
            next();
        end
        @(negedge clk);
        n_cmp++;
        if (ram_addr !== 10'd0 || ram_din !== 32'd0) begin
            n_err++;
            $display("FAIL reset_addr_din: got addr=%h din=%h, expected 0/0", ram_addr, ram_din);
        end
        next();
        rst_n = 1'b1;
        we[0] = 4'h0; we[1] = 4'h0;
        @(negedge clk);
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b01) begin
            n_err++;
            $display("FAIL first_grant: got %b, expected 01", {gnt1, gnt0});
        end
        n_cmp++;
        if (ram_we !== 4'd0) begin
            n_err++;
            $display("FAIL post_reset_we: got %h, expected 0", ram_we);
        end
        next();
        idle(3);
    endtask

    task automatic test_write_read();
        req = 2'b01; lock = 2'b00;
        we[0] = 4'hF; addr[0] = 10'd5; wdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++;
        if (gnt0 !== 1'b1) begin
            n_err++;
            $display("FAIL wr_gnt: got %b, expected 1", gnt0);
        end
        next();
        we[0] = 4'h0;
        @(negedge clk);
        n_cmp++;
        if (ram_we !== 4'hF || ram_addr !== 10'd5 || ram_din !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL wr_issue: got we=%h addr=%h din=%h, expected F/5/deadbeef", ram_we, ram_addr, ram_din);
        end
        next();
        req = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b1 || rdata0 !== 32'd0) begin
            n_err++;
            $display("FAIL wr_ack: got ack=%b rdata=%h, expected 1/0", ack0, rdata0);
        end
        next();
        @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL rd_after_wr: got ack=%b rdata=%h, expected 1/deadbeef", ack0, rdata0);
        end
        next();
        idle(2);
    endtask

    task automatic test_byte_write();
        for (int k = 0; k < 5; k++) begin
            req = (k < 3) ? 2'b10 : 2'b00;
            lock = 2'b00;
            addr[1] = 10'd7;
            case (k)
                0:       begin we[1] = 4'hF; wdata[1] = 32'h1122_3344; end
                1:       begin we[1] = 4'h1; wdata[1] = 32'h0000_00AA; end
                default: begin we[1] = 4'h0; wdata[1] = 32'd0; end
            endcase
            @(negedge clk);
            if (k == 4) begin
                n_cmp++;
                if (ack1 !== 1'b1 || rdata1 !== 32'h1122_33AA) begin
                    n_err++;
                    $display("FAIL byte_write: got ack=%b rdata=%h, expected 1/112233aa", ack1, rdata1);
                end
            end
            next();
        end
        idle(2);
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        req = 2'b11; lock = 2'b00;
        we[0] = 4'h0; we[1] = 4'h0; addr[0] = 10'd1; addr[1] = 10'd2;
        for (int i = 0; i < 6; i++) begin
            exp_g = (rr_mode && (i % 2 == 1)) ? 2'b10 : 2'b01;
            @(negedge clk);
            n_cmp++;
            if ({gnt1, gnt0} !== exp_g) begin
                n_err++;
                $display("FAIL contention_%0d: got %b, expected %b", i, {gnt1, gnt0}, exp_g);
            end
            next();
        end
        idle(3);
    endtask

    task automatic test_lock();
        logic [1:0] pat_req  [5] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b01};
        logic [1:0] pat_lock [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        logic [1:0] exp_g    [5] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b01};
        we[0] = 4'h0; we[1] = 4'h0; addr[0] = 10'd3; addr[1] = 10'd4;
        for (int i = 0; i < 5; i++) begin
            req = pat_req[i];
            lock = pat_lock[i];
            @(negedge clk);
            n_cmp++;
            if ({gnt1, gnt0} !== exp_g[i]) begin
                n_err++;
                $display("FAIL lock_%0d: got %b, expected %b", i, {gnt1, gnt0}, exp_g[i]);
            end
            next();
        end
        idle(3);
    endtask

    task automatic test_mid_reset();
        req = 2'b01; lock = 2'b01; we[0] = 4'h0; addr[0] = 10'd5;
        @(negedge clk);
        n_cmp++;
        if (gnt0 !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_gnt: got %b, expected 1", gnt0);
        end
        next();
        req = 2'b00; rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        req = 2'b10; we[1] = 4'h0; addr[1] = 10'd6;
        @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b0 || ram_ren !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_flush: got ack0=%b ren=%b, expected 0/0", ack0, ram_ren);
        end
        n_cmp++;
        if (gnt1 !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_idle: got gnt1=%b, expected 1", gnt1);
        end
        next();
        idle(3);
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        int          owner = -1;
        int          last = 1;
        logic [1:0]  eg;
        logic [31:0] d;
        int          m;
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        q.push_back('{0, 0, 0, 32'd0});
        q.push_back('{0, 0, 0, 32'd0});
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            e = q.pop_front();
            n_cmp++;
            if ({ack1, ack0} !== {e.v && e.m, e.v && !e.m}) begin
                n_err++;
                $display("FAIL rand_ack c%0d: got %b, expected %b", c, {ack1, ack0}, {e.v && e.m, e.v && !e.m});
            end
            n_cmp++;
            if (rdata0 !== ((e.v && !e.m && e.rd) ? e.data : 32'd0)) begin
                n_err++;
                $display("FAIL rand_rdata0 c%0d: got %h, expected %h", c, rdata0, (e.v && !e.m && e.rd) ? e.data : 32'd0);
            end
            n_cmp++;
            if (rdata1 !== ((e.v && e.m && e.rd) ? e.data : 32'd0)) begin
                n_err++;
                $display("FAIL rand_rdata1 c%0d: got %h, expected %h", c, rdata1, (e.v && e.m && e.rd) ? e.data : 32'd0);
            end

            eg = 2'b00;
            if (owner >= 0)              eg[owner] = req[owner];
            else if (req == 2'b11)       eg = rr_mode ? ((last == 1) ? 2'b01 : 2'b10) : 2'b01;
            else                         eg = req;
            n_cmp++;
            if ({gnt1, gnt0} !== eg) begin
                n_err++;
                $display("FAIL rand_gnt c%0d: got %b, expected %b", c, {gnt1, gnt0}, eg);
            end

            if (eg != 2'b00) begin
                m = eg[1] ? 1 : 0;
                if (we[m] == 4'h0) begin
                    d = ref_mem[addr[m]];
                end else begin
                    d = ref_mem[addr[m]];
                    for (int b = 0; b < 4; b++)
                        if (we[m][b]) d[8*b +: 8] = wdata[m][8*b +: 8];
                    ref_mem[addr[m]] = d;
                end
                q.push_back('{1, m[0], we[m] == 4'h0, d});
                last = m;
                if (owner < 0) begin
                    if (lock[m]) owner = m;
                end else if (!lock[m]) begin
                    owner = -1;
                end
            end else begin
                q.push_back('{0, 0, 0, 32'd0});
            end
            if (owner >= 0 && !req[owner] && !lock[owner]) owner = -1;

            next();
            for (int k = 0; k < 2; k++) begin
                if (c >= 396) begin
                    req[k] = 1'b0;
                    lock[k] = 1'b0;
                end else if (eg[k] || !req[k]) begin
                    req[k]   = ($urandom_range(0, 3) != 0);
                    we[k]    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                    addr[k]  = 10'($urandom_range(16, 31));
                    wdata[k] = $urandom;
                    lock[k]  = ($urandom_range(0, 3) == 0);
                end
            end
        end
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
        ram_clear = 1'b1;
        rst_n = 1'b0;
        req = 2'b00; lock = 2'b00;
        we[0] = 4'h0; we[1] = 4'h0;
        addr[0] = 10'd0; addr[1] = 10'd0;
        wdata[0] = 32'd0; wdata[1] = 32'd0;
        next();
        next();
        ram_clear = 1'b0;

        test_reset();
        test_write_read();
        test_byte_write();
        test_contention();
        test_lock();
        test_mid_reset();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
